// File: rtl/pipeline_run_control.sv
// Run/step/stop controller for the five-stage pipeline: turns debug commands into
// PC and pipeline-register halts, drains after a HALT instruction, and counts active cycles.
module pipeline_run_control #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  input  logic [1:0]  i_cmd,
  output logic        o_cmd_ready,
  input  logic        i_halt_instr,
  output logic        o_pc_halt,
  output logic        o_pipe_halt,
  output logic        o_done,
  output logic [31:0] o_cycle_count,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] CMD_RUN   = 2'b00;
  localparam logic [1:0] CMD_STEP  = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  drain_q, drain_d;
  logic [31:0] count_q, count_d;
  logic        cmd_acc;
  logic        clear;

  // Handshake: a command transfers when i_cmd_valid && o_cmd_ready on a rising edge;
  // o_cmd_ready depends only on registered state, never on i_cmd_valid.
  assign o_cmd_ready   = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_DONE);
  assign o_pc_halt     = !((state_q == S_RUN) || (state_q == S_STEP));
  assign o_pipe_halt   = !((state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN));
  assign o_done        = (state_q == S_DONE);
  assign o_cycle_count = count_q;
  assign o_state       = state_q;
  assign cmd_acc       = i_cmd_valid && o_cmd_ready;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    clear   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          case (i_cmd)
            CMD_RUN:   state_d = S_RUN;
            CMD_STEP:  state_d = S_STEP;
            CMD_CLEAR: clear   = 1'b1;
            default:   ;
          endcase
        end
      end
      S_RUN: begin
        // A HALT decoded in the same cycle as STOP still drains.
        if (i_halt_instr) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (cmd_acc && (i_cmd == CMD_STOP)) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (i_halt_instr) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (drain_q == 4'd0) state_d = S_DONE;
        else                 drain_d = drain_q - 4'd1;
      end
      S_DONE: begin
        if (cmd_acc && (i_cmd == CMD_CLEAR)) begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        drain_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (clear)                                count_d = 32'd0;
    else if (!o_pipe_halt && (count_q != '1)) count_d = count_q + 32'd1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      drain_q <= 4'd0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      count_q <= count_d;
    end
  end

endmodule
